// File: rtl/memory_stage_pkg.sv
// Shared MIPS pipeline definitions used by the MEM stage: control-bit indices,
// default widths and the data-memory access FSM state type.
package memory_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // wb bundle bit positions
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // m bundle bit positions
  localparam int M_BRANCH    = 2;
  localparam int M_MEM_READ  = 1;
  localparam int M_MEM_WRITE = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the
// data memory (slave).
interface memory_stage_if #(
  parameter int DATA_W = memory_stage_pkg::DATA_W
);

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/memory_stage_mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears only the valid and wb control bits;
// a load captures the whole bundle; otherwise the register holds.
module mem_wb_reg #(
  parameter int DATA_W = memory_stage_pkg::DATA_W,
  parameter int REG_W  = memory_stage_pkg::REG_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              bubble,
  input  logic              valid_d,
  input  logic [1:0]        wb_d,
  input  logic [DATA_W-1:0] read_data_d,
  input  logic [DATA_W-1:0] alu_result_d,
  input  logic [REG_W-1:0]  rd_d,
  output logic              valid_q,
  output logic [1:0]        wb_q,
  output logic [DATA_W-1:0] read_data_q,
  output logic [DATA_W-1:0] alu_result_q,
  output logic [REG_W-1:0]  rd_q
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      wb_q         <= '0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      rd_q         <= '0;
    end else if (bubble) begin
      valid_q <= 1'b0;
      wb_q    <= '0;
    end else if (load) begin
      valid_q      <= valid_d;
      wb_q         <= wb_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: issues loads/stores over the dmem handshake, stalls upstream while
// an access is outstanding, and owns the MEM/WB register plus forwarding value.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_W = memory_stage_pkg::DATA_W,
  parameter int REG_W  = memory_stage_pkg::REG_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  valid_in,
  input  logic [1:0]            wb_in,
  input  logic [2:0]            m_in,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_W-1:0]      rd_in,
  output logic                  stall_out,
  memory_stage_if.master        dmem,
  output logic                  mem_wb_valid,
  output logic [1:0]            mem_wb_wb,
  output logic [DATA_W-1:0]     mem_wb_read_data,
  output logic [DATA_W-1:0]     mem_wb_alu_result,
  output logic [REG_W-1:0]      mem_wb_register_rd,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  misaligned
);

  mem_state_e state_q, state_d;

  logic memop;
  logic aligned;
  logic issue;
  logic done;
  logic wb_load;
  logic wb_bubble;
  logic misalign_d;
  logic [DATA_W-1:0] read_data_d;
  logic unused_branch;

  assign unused_branch = m_in[M_BRANCH];
  assign memop   = valid_in & (m_in[M_MEM_READ] | m_in[M_MEM_WRITE]);
  assign aligned = (alu_result[1:0] == 2'b00);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    stall_out  = 1'b0;
    issue      = 1'b0;
    done       = 1'b0;
    wb_load    = 1'b0;
    wb_bubble  = 1'b1;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop && aligned) begin
          state_d   = ACCESS;
          stall_out = 1'b1;
          issue     = 1'b1;
        end else if (memop) begin
          misalign_d = 1'b1;
        end else if (valid_in) begin
          wb_load   = 1'b1;
          wb_bubble = 1'b0;
        end
      end
      ACCESS: begin
        if (dmem.dmem_ack) begin
          state_d   = IDLE;
          done      = 1'b1;
          wb_load   = 1'b1;
          wb_bubble = 1'b0;
        end else begin
          stall_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only a completing load carries memory data into MEM/WB.
  assign read_data_d = (done && !dmem.dmem_we) ? dmem.dmem_rdata : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      misaligned      <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
    end else begin
      state_q    <= state_d;
      misaligned <= misalign_d;
      if (issue) begin
        // Store wins when both mem_read and mem_write are set.
        dmem.dmem_req   <= 1'b1;
        dmem.dmem_we    <= m_in[M_MEM_WRITE];
        dmem.dmem_addr  <= alu_result;
        dmem.dmem_wdata <= store_data;
      end else if (done) begin
        dmem.dmem_req <= 1'b0;
      end
    end
  end

  // On the ack edge EX/MEM still holds the stalled memop, so the live inputs
  // are the bundle that completes.
  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (wb_load),
    .bubble       (wb_bubble),
    .valid_d      (valid_in),
    .wb_d         (wb_in),
    .read_data_d  (read_data_d),
    .alu_result_d (alu_result),
    .rd_d         (rd_in),
    .valid_q      (mem_wb_valid),
    .wb_q         (mem_wb_wb),
    .read_data_q  (mem_wb_read_data),
    .alu_result_q (mem_wb_alu_result),
    .rd_q         (mem_wb_register_rd)
  );

  assign fwd_data = mem_wb_wb[WB_MEM_TO_REG] ? mem_wb_read_data : mem_wb_alu_result;

endmodule

// File: doc/memory_stage.md
# memory_stage

MEM stage of the 5-stage MIPS pipeline. It consumes the EX/MEM register bundle, runs loads and stores against the data memory over a request/acknowledge handshake, and stalls the upstream stages while an access is outstanding. It also owns the MEM/WB pipeline register and drives the MEM/WB write-back value and destination back to the EX-stage forwarding unit and muxes.

## Interface
- DATA_W, 32, data and address width
- REG_W, 5, register index width
- clock  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_in  in  1  EX/MEM holds a real instruction
- wb_in  in  2  [1] reg_write, [0] mem_to_reg
- m_in  in  3  [2] branch (ignored here), [1] mem_read, [0] mem_write
- alu_result  in  DATA_W  address for memory ops, result otherwise
- store_data  in  DATA_W  forwarded rt value for stores
- rd_in  in  REG_W  destination register
- stall_out  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DATA_W  word-aligned byte address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- mem_wb_valid  out  1  MEM/WB holds a real instruction
- mem_wb_wb  out  2  registered wb bits
- mem_wb_read_data  out  DATA_W  registered load data
- mem_wb_alu_result  out  DATA_W  registered ALU result
- mem_wb_register_rd  out  REG_W  registered destination
- fwd_data  out  DATA_W  write-back value: read_data if mem_to_reg, else alu_result
- misaligned  out  1  one-cycle pulse for a dropped misaligned access

## Operation
- Memop = valid_in & (mem_read | mem_write). Store takes priority if both bits are set.
- FSM states:
  - IDLE -> ACCESS on an aligned memop.
  - ACCESS -> IDLE on dmem_ack.
- Non-memop in IDLE: MEM/WB loads the bundle at the next edge. No stall.
- Aligned memop in IDLE:
  - At the next edge, register dmem_req=1, dmem_we, dmem_addr and dmem_wdata, and enter ACCESS.
  - MEM/WB gets a bubble (mem_wb_valid=0, mem_wb_wb=0).
- ACCESS:
  - dmem_req, dmem_addr, dmem_wdata and dmem_we stay stable until dmem_ack.
  - On ack, MEM/WB captures the bundle plus dmem_rdata (loads only; stores capture 0), dmem_req drops and the FSM returns to IDLE.
  - Without ack, MEM/WB gets a bubble.
- stall_out is combinational: (IDLE & aligned memop) | (ACCESS & ~dmem_ack).
- Misaligned memop (alu_result[1:0] != 0):
  - No request is issued and the instruction becomes a bubble in MEM/WB.
  - misaligned pulses high for the cycle after the edge.
  - No stall.
- fwd_data is combinational from the MEM/WB registers.
- dmem_ack while in IDLE is ignored.
- valid_in=0 gives a bubble regardless of the wb/m bits.

## Timing
- Reset values: all outputs 0, FSM in IDLE. Assertion clears them immediately (asynchronous), including mid-access. An ack arriving after reset is ignored.
- Non-memop latency: MEM/WB valid 1 cycle after presentation.
- Memop, ack in the first ACCESS cycle:
  - Presented in cycle N, dmem_req high in N+1, MEM/WB valid in N+2.
  - stall_out high in N only.
- Each extra wait cycle adds one cycle of stall and latency.
- On the ack edge the next EX/MEM instruction advances at the same edge. Back-to-back memops therefore issue the next request one cycle after the ack cycle.

## Structure
- Shared pipeline package holds:
  - WB_REG_WRITE/WB_MEM_TO_REG and M_BRANCH/M_MEM_READ/M_MEM_WRITE bit indices
  - the FSM state typedef {IDLE, ACCESS}
  - the DATA_W and REG_W defaults
- The MEM/WB register is one natural sub-module, mem_wb_reg. It has load and bubble controls and an asynchronous active-low clear.

## Test plan
- Non-memop ALU op, rd=5, alu_result=0x10, reg_write=1:
  - Next cycle mem_wb_valid=1, mem_wb_register_rd=5, fwd_data=0x10.
  - stall_out never high.
- Load at 0x100, ack in the first ACCESS cycle, rdata=0xDEADBEEF:
  - stall_out high for 1 cycle, dmem_req for 1 cycle.
  - mem_wb_read_data=0xDEADBEEF and fwd_data=0xDEADBEEF at N+2.
- Store at 0x200 with data 0x1234, ack delayed 3 cycles:
  - dmem_addr and dmem_wdata stay stable 3 cycles, stall_out high 3 cycles.
  - Bubbles in MEM/WB until ack.
- Load at 0x102: misaligned=1 for one cycle, dmem_req stays 0, mem_wb_valid=0.
- Reset asserted mid-ACCESS, then a late ack:
  - All outputs 0 immediately, FSM in IDLE.
  - The ack produces no MEM/WB write.
- Load followed directly by an ALU op: the ALU op reaches MEM/WB on the cycle after the load, with no lost or duplicated instruction.
